// File: rtl/pipe_mult_unit.sv
// rtl/pipe_mult_unit.sv - pipelined RV32M multiplier FU with branch-mask squash/clear and valid/ready flow
// Optional early wakeup: define PIPE_MULT_EARLY_DONE_EN to drive will_done one cycle ahead of out_valid.
module pipe_mult_unit #(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 4,
    parameter int BRAT_SIZE  = 4,
    parameter int TAG_W      = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_func,
    input  logic [XLEN-1:0]      in_opa,
    input  logic [XLEN-1:0]      in_opb,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic [BRAT_SIZE-1:0] in_brat_mask,
    input  logic                 brat_mis_valid,
    input  logic [BRAT_SIZE-1:0] brat_mis,
    input  logic                 brat_clr_valid,
    input  logic [BRAT_SIZE-1:0] brat_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic [BRAT_SIZE-1:0] out_brat_mask,
    output logic                 will_done
);
    localparam int CH = XLEN / NUM_STAGES;
    localparam int PW = 2 * XLEN;
    localparam logic [1:0] F_MUL    = 2'b00;
    localparam logic [1:0] F_MULH   = 2'b01;
    localparam logic [1:0] F_MULHSU = 2'b10;

    logic [NUM_STAGES-1:0] v_q, v_d, adv, kill;
    logic [1:0]            func_q [NUM_STAGES];
    logic [1:0]            func_d [NUM_STAGES];
    logic [PW-1:0]         a_q    [NUM_STAGES];
    logic [PW-1:0]         a_d    [NUM_STAGES];
    logic [XLEN:0]         b_q    [NUM_STAGES];
    logic [XLEN:0]         b_d    [NUM_STAGES];
    logic [PW-1:0]         acc_q  [NUM_STAGES];
    logic [PW-1:0]         acc_d  [NUM_STAGES];
    logic [TAG_W-1:0]      tag_q  [NUM_STAGES];
    logic [TAG_W-1:0]      tag_d  [NUM_STAGES];
    logic [BRAT_SIZE-1:0]  mask_q [NUM_STAGES];
    logic [BRAT_SIZE-1:0]  mask_d [NUM_STAGES];
    logic [BRAT_SIZE-1:0]  eff_mask [NUM_STAGES];

    logic [PW-1:0]         in_a;
    logic [XLEN:0]         in_b;
    logic                  kill_in;
    logic [BRAT_SIZE-1:0]  in_mask_eff;

    // Stage k adds the partial products of its opb slice; the extension bit of opb
    // has negative weight and is folded in by the final stage.
    function automatic logic [PW-1:0] accum(input logic [PW-1:0] acc, input logic [PW-1:0] a,
                                            input logic [XLEN:0] b, input int k);
        logic [PW-1:0] s;
        s = acc;
        for (int j = 0; j < CH; j++) begin
            if (b[k*CH+j]) s = s + (a << (k*CH+j));
        end
        if ((k == NUM_STAGES-1) && b[XLEN]) s = s - (a << XLEN);
        return s;
    endfunction

    always_comb begin
        in_a        = (in_func == F_MULH || in_func == F_MULHSU) ?
                      {{XLEN{in_opa[XLEN-1]}}, in_opa} : {{XLEN{1'b0}}, in_opa};
        in_b        = {(in_func == F_MULH) & in_opb[XLEN-1], in_opb};
        kill_in     = brat_mis_valid && ((in_brat_mask & brat_mis) != '0);
        in_mask_eff = brat_clr_valid ? (in_brat_mask & ~brat_clr) : in_brat_mask;
    end

    always_comb begin
        kill = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            kill[i]     = brat_mis_valid && ((mask_q[i] & brat_mis) != '0);
            eff_mask[i] = brat_clr_valid ? (mask_q[i] & ~brat_clr) : mask_q[i];
        end
    end

    // A stage may advance when any stage ahead of it is empty or the output drains.
    // Raw valids are used so squashes never ripple into in_ready.
    always_comb begin
        adv = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            adv[i] = out_ready || !v_q[NUM_STAGES-1];
            for (int j = i + 1; j < NUM_STAGES; j++) begin
                if (!v_q[j]) adv[i] = 1'b1;
            end
        end
    end

    assign in_ready = !v_q[0] || adv[0];

    always_comb begin
        v_d    = v_q & ~kill;
        func_d = func_q;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        tag_d  = tag_q;
        mask_d = eff_mask;
        if (in_ready) begin
            v_d[0] = in_valid && !kill_in;
            if (in_valid) begin
                func_d[0] = in_func;
                a_d[0]    = in_a;
                b_d[0]    = in_b;
                acc_d[0]  = accum('0, in_a, in_b, 0);
                tag_d[0]  = in_tag;
                mask_d[0] = in_mask_eff;
            end
        end
        for (int i = 1; i < NUM_STAGES; i++) begin
            if (adv[i-1]) begin
                v_d[i] = v_q[i-1] && !kill[i-1];
                if (v_q[i-1]) begin
                    func_d[i] = func_q[i-1];
                    a_d[i]    = a_q[i-1];
                    b_d[i]    = b_q[i-1];
                    acc_d[i]  = accum(acc_q[i-1], a_q[i-1], b_q[i-1], i);
                    tag_d[i]  = tag_q[i-1];
                    mask_d[i] = eff_mask[i-1];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v_q    <= '0;
            func_q <= '{default: '0};
            a_q    <= '{default: '0};
            b_q    <= '{default: '0};
            acc_q  <= '{default: '0};
            tag_q  <= '{default: '0};
            mask_q <= '{default: '0};
        end else begin
            v_q    <= v_d;
            func_q <= func_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            tag_q  <= tag_d;
            mask_q <= mask_d;
        end
    end

    assign out_valid     = v_q[NUM_STAGES-1] && !kill[NUM_STAGES-1];
    assign out_result    = (func_q[NUM_STAGES-1] == F_MUL) ? acc_q[NUM_STAGES-1][XLEN-1:0]
                                                           : acc_q[NUM_STAGES-1][PW-1:XLEN];
    assign out_tag       = tag_q[NUM_STAGES-1];
    assign out_brat_mask = eff_mask[NUM_STAGES-1];

`ifdef PIPE_MULT_EARLY_DONE_EN
    if (NUM_STAGES == 1) begin : g_wd_single
        assign will_done = in_valid && in_ready && !kill_in;
    end else begin : g_wd_multi
        assign will_done = v_q[NUM_STAGES-2] && !kill[NUM_STAGES-2] && adv[NUM_STAGES-2]
                           && !(out_valid && !out_ready);
    end
`else
    assign will_done = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_mult_unit.sv
// tb/tb_pipe_mult_unit.sv - randomized and directed bench for pipe_mult_unit against an in-order queue model
module tb_pipe_mult_unit;
    localparam int NS = 4;

    logic        clock, reset;
    logic        in_valid, in_ready;
    logic [1:0]  in_func;
    logic [31:0] in_opa, in_opb;
    logic [5:0]  in_tag;
    logic [3:0]  in_brat_mask;
    logic        brat_mis_valid, brat_clr_valid;
    logic [3:0]  brat_mis, brat_clr;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [5:0]  out_tag;
    logic [3:0]  out_brat_mask;
    logic        will_done;

    pipe_mult_unit dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
        .in_opa(in_opa), .in_opb(in_opb), .in_tag(in_tag), .in_brat_mask(in_brat_mask),
        .brat_mis_valid(brat_mis_valid), .brat_mis(brat_mis),
        .brat_clr_valid(brat_clr_valid), .brat_clr(brat_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_brat_mask(out_brat_mask), .will_done(will_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic [5:0]  tag;
        logic [3:0]  mask;
    } ent_t;

    ent_t mq[$];
    ent_t fired_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mref(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (f)
            2'd1:    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            2'd2:    p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
            default: p = {32'b0, a} * {32'b0, b};
        endcase
        return (f == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    ent_t        cur;
    logic [3:0]  em;

    always @(negedge clock) begin
        if (reset) begin
            mq.delete();
        end else begin
            chk("in_ready", 64'(in_ready), 64'((mq.size() < NS) || out_ready));
            if (out_valid) begin
                if (mq.size() == 0) begin
                    chk("spurious_out_valid", 64'(out_valid), 64'(0));
                end else begin
                    em = brat_clr_valid ? (mq[0].mask & ~brat_clr) : mq[0].mask;
                    chk("out_result", 64'(out_result), 64'(mq[0].res));
                    chk("out_tag", 64'(out_tag), 64'(mq[0].tag));
                    chk("out_brat_mask", 64'(out_brat_mask), 64'(em));
                    chk("out_not_squashed", 64'(brat_mis_valid && ((mq[0].mask & brat_mis) != 0)), 64'(0));
                    if (out_ready) begin
                        cur = mq[0];
                        cur.mask = em;
                        fired_q.push_back(cur);
                        mq.pop_front();
                    end
                end
            end
            if (brat_mis_valid) begin
                for (int i = mq.size() - 1; i >= 0; i--)
                    if ((mq[i].mask & brat_mis) != 0) mq.delete(i);
            end
            if (brat_clr_valid) begin
                for (int i = 0; i < mq.size(); i++) mq[i].mask = mq[i].mask & ~brat_clr;
            end
            if (in_valid && in_ready && !(brat_mis_valid && ((in_brat_mask & brat_mis) != 0))) begin
                cur.res  = mref(in_func, in_opa, in_opb);
                cur.tag  = in_tag;
                cur.mask = brat_clr_valid ? (in_brat_mask & ~brat_clr) : in_brat_mask;
                mq.push_back(cur);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        brat_mis_valid = 1'b0;
        brat_clr_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] t, input logic [3:0] m);
        in_valid = 1'b1;
        in_func = f;
        in_opa = a;
        in_opb = b;
        in_tag = t;
        in_brat_mask = m;
    endtask

    task automatic drain();
        int c;
        c = 0;
        idle();
        out_ready = 1'b1;
        while (mq.size() != 0 && c < 60) begin
            tick();
            c++;
        end
        chk("drain_timeout", 64'(mq.size()), 64'(0));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic saw_not_ready;
        int   n, cyc;
        reset = 1'b1;
        out_ready = 1'b1;
        in_func = 2'd0; in_opa = '0; in_opb = '0; in_tag = '0; in_brat_mask = '0;
        brat_mis = '0; brat_clr = '0;
        idle();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_will_done", 64'(will_done), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_result", 64'(out_result), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        chk("rst_out_mask", 64'(out_brat_mask), 64'(0));
        tick();

        // MUL 2*3: result at cycle +4, early done at cycle +3 when enabled
        issue(2'd0, 32'd2, 32'd3, 6'd5, 4'd0);
        tick();
        idle();
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            chk("t1_out_valid", 64'(out_valid), 64'(k == 4));
`ifdef PIPE_MULT_EARLY_DONE_EN
            chk("t1_will_done", 64'(will_done), 64'(k == 3));
`else
            chk("t1_will_done", 64'(will_done), 64'(0));
`endif
            if (k == 4) begin
                chk("t1_result", 64'(out_result), 64'd6);
                chk("t1_tag", 64'(out_tag), 64'd5);
            end
        end
        tick();

        // back-to-back MULH / MUL, then MULHU / MULHSU on all-ones operands
        for (int t = 0; t < 2; t++) begin
            issue(t == 0 ? 2'd1 : 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'(1 + 2*t), 4'd0);
            tick();
            issue(t == 0 ? 2'd0 : 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'(2 + 2*t), 4'd0);
            tick();
            idle();
            for (int k = 2; k <= 6; k++) begin
                @(negedge clock);
                chk("t23_out_valid", 64'(out_valid), 64'(k == 4 || k == 5));
                if (k == 4) begin
                    chk("t23_first_result", 64'(out_result), t == 0 ? 64'h0 : 64'hFFFF_FFFE);
                    chk("t23_first_tag", 64'(out_tag), 64'(1 + 2*t));
                end
                if (k == 5) begin
                    chk("t23_second_result", 64'(out_result), t == 0 ? 64'h1 : 64'hFFFF_FFFF);
                    chk("t23_second_tag", 64'(out_tag), 64'(2 + 2*t));
                end
            end
            tick();
        end

        // stream of 6 with a 3-cycle output stall
        fired_q.delete();
        saw_not_ready = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 6 && cyc < 100) begin
            issue(2'($urandom), pick(), pick(), 6'(10 + n), 4'd0);
            out_ready = !(cyc >= 3 && cyc < 6);
            @(negedge clock);
            if (!in_ready) saw_not_ready = 1'b1;
            else n++;
            tick();
            cyc++;
        end
        drain();
        chk("t4_in_ready_fell", 64'(saw_not_ready), 64'(1));
        chk("t4_count", 64'(fired_q.size()), 64'd6);
        for (int i = 0; i < fired_q.size(); i++) chk("t4_order", 64'(fired_q[i].tag), 64'(10 + i));

        // simultaneous mispredict and clear on different branches
        fired_q.delete();
        issue(2'd0, 32'd3, 32'd4, 6'd20, 4'b0001);
        tick();
        issue(2'd0, 32'd5, 32'd6, 6'd21, 4'b0010);
        tick();
        issue(2'd0, 32'd7, 32'd8, 6'd22, 4'b0000);
        tick();
        in_valid = 1'b0;
        brat_mis_valid = 1'b1; brat_mis = 4'b0001;
        brat_clr_valid = 1'b1; brat_clr = 4'b0010;
        tick();
        drain();
        chk("t5_count", 64'(fired_q.size()), 64'd2);
        if (fired_q.size() == 2) begin
            chk("t5_first_tag", 64'(fired_q[0].tag), 64'd21);
            chk("t5_first_mask", 64'(fired_q[0].mask), 64'd0);
            chk("t5_first_result", 64'(fired_q[0].res), 64'd30);
            chk("t5_second_tag", 64'(fired_q[1].tag), 64'd22);
        end

        // reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            issue(2'd0, 32'(i + 1), 32'd9, 6'(30 + i), 4'd0);
            tick();
        end
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("t6_out_valid_after_reset", 64'(out_valid), 64'(0));
        chk("t6_in_ready_after_reset", 64'(in_ready), 64'(1));
        chk("t6_result_after_reset", 64'(out_result), 64'(0));
        tick();
        issue(2'd0, 32'd7, 32'd6, 6'd33, 4'd0);
        tick();
        idle();
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            chk("t6_out_valid", 64'(out_valid), 64'(k == 4));
            if (k == 4) chk("t6_result", 64'(out_result), 64'd42);
        end
        tick();

        // randomized traffic with backpressure, squashes and clears
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            in_func = 2'($urandom);
            in_opa = pick();
            in_opb = pick();
            in_tag = 6'($urandom);
            in_brat_mask = ($urandom_range(0, 99) < 50) ? 4'd0 : 4'($urandom);
            out_ready = ($urandom_range(0, 99) < 70);
            brat_mis_valid = ($urandom_range(0, 99) < 8);
            brat_mis = 4'(1 << $urandom_range(0, 3));
            brat_clr_valid = ($urandom_range(0, 99) < 12);
            brat_clr = 4'(1 << $urandom_range(0, 3));
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
